// File: rtl/uart_pkg.sv
// uart_pkg: shared UART types, oversampling constants and baud divisor helper
package uart_pkg;
    typedef enum logic [2:0] {IDLE, START, DATA, STOP, WAIT_HIGH} rx_state_t;
    localparam int OVERSAMPLE = 16;
    localparam int MID_TICK = 8;
    function automatic int calc_div(input int clk_hz, input int baud);
        int d;
        d = (clk_hz + baud * OVERSAMPLE / 2) / (baud * OVERSAMPLE);
        return d < 1 ? 1 : d;
    endfunction
endpackage

// File: rtl/uart_rx_sampler_if.sv
// uart_rx_sampler_if: serial line input plus valid/ready byte output bundle
interface uart_rx_sampler_if;
    logic       rx;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_ready;
    logic       frame_err;
    logic       overrun;
    logic       busy;
    modport master (input rx, rx_ready, output rx_data, rx_valid, frame_err, overrun, busy);
    modport slave (output rx, rx_ready, input rx_data, rx_valid, frame_err, overrun, busy);
endinterface

// File: rtl/uart_baud_tick.sv
// uart_baud_tick: free-running 1-cycle tick every DIV clocks, phase restartable
module uart_baud_tick #(
    parameter int DIV = 1
) (
    input  logic clk,
    input  logic rst,
    input  logic restart,
    output logic tick
);
    localparam int W = DIV > 1 ? $clog2(DIV) : 1;
    logic [W-1:0] cnt;
    assign tick = cnt == W'(DIV - 1);
    always_ff @(posedge clk) cnt <= (rst || restart || tick) ? '0 : cnt + 1'b1;
endmodule

// File: rtl/uart_rx_sampler.sv
// uart_rx_sampler: 8N1 UART receiver with 16x oversampling, one-byte holding
// register on a valid/ready port, frame error and overrun pulses.
module uart_rx_sampler
    import uart_pkg::*;
#(
    parameter int CLK_HZ = 50_000_000,
    parameter int BAUD = 115_200,
    parameter int OVERSAMPLE = 16
) (
    input logic clk,
    input logic rst,
    uart_rx_sampler_if.master bus
);
    if (OVERSAMPLE != uart_pkg::OVERSAMPLE) begin : g_bad_oversample
        $fatal(1, "uart_rx_sampler supports only OVERSAMPLE=16");
    end
    localparam logic [3:0] LAST_TICK = 4'(OVERSAMPLE - 1);
    localparam logic [3:0] MID_LAST = 4'(MID_TICK - 1);
    rx_state_t state;
    logic sync1, rx_s, tick, restart, done;
    logic [3:0] tcnt;
    logic [2:0] bcnt;
    logic [7:0] shreg, data_q;
    logic valid_q, fe_q, ov_q, busy_q;
    assign restart = state == IDLE && !rx_s;
    uart_baud_tick #(.DIV(calc_div(CLK_HZ, BAUD))) u_tick (
        .clk(clk), .rst(rst), .restart(restart), .tick(tick)
    );
    always_ff @(posedge clk) begin
        if (rst) begin
            {sync1, rx_s} <= 2'b11;
            state <= IDLE;
            tcnt <= '0;
            bcnt <= '0;
            shreg <= '0;
            data_q <= '0;
            {done, valid_q, fe_q, ov_q, busy_q} <= '0;
        end else begin
            {sync1, rx_s} <= {bus.rx, sync1};
            {done, fe_q, ov_q} <= '0;
            case (state)
                IDLE: if (!rx_s) begin
                    tcnt <= '0;
                    busy_q <= 1'b1;
                    state <= START;
                end
                START: if (tick) begin
                    tcnt <= tcnt == MID_LAST ? '0 : tcnt + 4'd1;
                    if (tcnt == MID_LAST) begin
                        bcnt <= '0;
                        busy_q <= !rx_s;
                        state <= rx_s ? IDLE : DATA;
                    end
                end
                DATA: if (tick) begin
                    tcnt <= tcnt + 4'd1;
                    if (tcnt == LAST_TICK) begin
                        shreg <= {rx_s, shreg[7:1]};
                        bcnt <= bcnt + 3'd1;
                        if (bcnt == 3'd7) state <= STOP;
                    end
                end
                STOP: if (tick) begin
                    tcnt <= tcnt + 4'd1;
                    if (tcnt == LAST_TICK) begin
                        done <= rx_s;
                        fe_q <= !rx_s;
                        busy_q <= !rx_s;
                        state <= rx_s ? IDLE : WAIT_HIGH;
                    end
                end
                WAIT_HIGH: if (rx_s) begin
                    busy_q <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
            // completion is the cycle after the stop sample; an accept in that cycle frees the slot
            if (done && valid_q && !bus.rx_ready) ov_q <= 1'b1;
            else if (done) begin
                data_q <= shreg;
                valid_q <= 1'b1;
            end else if (valid_q && bus.rx_ready) valid_q <= 1'b0;
        end
    end
    assign bus.rx_data = data_q;
    assign bus.rx_valid = valid_q;
    assign bus.frame_err = fe_q;
    assign bus.overrun = ov_q;
    assign bus.busy = busy_q;
endmodule

// File: tb/tb_uart_rx_sampler.sv
// tb_uart_rx_sampler: scoreboard bench for the UART receiver at 16 clocks per bit
module tb_uart_rx_sampler;
    logic clk = 1'b0;
    logic rst = 1'b1;
    uart_rx_sampler_if bus();
    uart_rx_sampler #(.CLK_HZ(1_600_000), .BAUD(100_000), .OVERSAMPLE(16)) dut (
        .clk(clk), .rst(rst), .bus(bus)
    );
    always #5 clk = ~clk;
    int checks = 0, errors = 0, cyc = 0;
    int fe_cnt = 0, ov_cnt = 0, both_cnt = 0, rises = 0, rise_cyc = 0, stop_cyc = 0;
    logic prev_v = 1'b0;
    logic [7:0] sb[$];
    always @(posedge clk) cyc <= cyc + 1;
    task automatic check(input string tag, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask
    always @(negedge clk) begin
        if (!rst) begin
            if (bus.rx_valid && bus.rx_ready) begin
                if (sb.size() == 0) check("sb_extra_byte", int'(bus.rx_data), -1);
                else check("sb_byte", int'(bus.rx_data), int'(sb.pop_front()));
            end
            if (bus.rx_valid && !prev_v) begin
                rises++;
                rise_cyc = cyc;
            end
            fe_cnt += int'(bus.frame_err);
            ov_cnt += int'(bus.overrun);
            both_cnt += int'(bus.frame_err && bus.overrun);
        end
        prev_v = bus.rx_valid;
    end
    task automatic drive_bit(input logic v);
        bus.rx = v;
        repeat (16) @(posedge clk);
        #1;
    endtask
    task automatic send_byte(input logic [7:0] b, input bit push, input logic stop);
        if (push) sb.push_back(b);
        drive_bit(1'b0);
        for (int i = 0; i < 8; i++) drive_bit(b[i]);
        stop_cyc = cyc;
        drive_bit(stop);
    endtask
    task automatic idle(input int n);
        bus.rx = 1'b1;
        repeat (n) @(posedge clk);
        #1;
    endtask
    initial begin
        int fe0, ov0, r0, lat, n;
        bus.rx = 1'b1;
        bus.rx_ready = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_data", int'(bus.rx_data), 0);
        check("rst_valid", int'(bus.rx_valid), 0);
        check("rst_busy", int'(bus.busy), 0);
        check("rst_pulses", int'({bus.frame_err, bus.overrun}), 0);
        @(posedge clk);
        #1 rst = 1'b0;
        idle(5);
        // single byte, consumer always ready
        fe0 = fe_cnt;
        send_byte(8'hA5, 1, 1'b1);
        idle(4);
        lat = rise_cyc - stop_cyc;
        check("t1_latency", (lat >= 11 && lat <= 13) ? 12 : lat, 12);
        check("t1_delivered", sb.size(), 0);
        check("t1_no_fe", fe_cnt - fe0, 0);
        check("t1_valid_low", int'(bus.rx_valid), 0);
        // back-to-back with stalled consumer: second byte dropped
        bus.rx_ready = 1'b0;
        ov0 = ov_cnt;
        send_byte(8'h3C, 1, 1'b1);
        check("t2_no_ov_first", ov_cnt - ov0, 0);
        send_byte(8'h81, 0, 1'b1);
        idle(4);
        check("t2_overrun", ov_cnt - ov0, 1);
        check("t2_valid_held", int'(bus.rx_valid), 1);
        check("t2_data_held", int'(bus.rx_data), 'h3C);
        bus.rx_ready = 1'b1;
        @(posedge clk);
        #1;
        @(negedge clk);
        check("t2_valid_drop", int'(bus.rx_valid), 0);
        check("t2_sb_empty", sb.size(), 0);
        // framing error followed by a 40-bit break
        idle(10);
        fe0 = fe_cnt;
        r0 = rises;
        send_byte(8'h55, 0, 1'b0);
        repeat (40 * 16) @(posedge clk);
        @(negedge clk);
        check("t3_busy_in_break", int'(bus.busy), 1);
        check("t3_one_fe", fe_cnt - fe0, 1);
        check("t3_no_valid", rises - r0, 0);
        @(posedge clk);
        #1;
        idle(6);
        check("t3_busy_released", int'(bus.busy), 0);
        send_byte(8'h12, 1, 1'b1);
        idle(4);
        check("t3_next_byte", sb.size(), 0);
        // 4-clock glitch on an idle line
        fe0 = fe_cnt;
        r0 = rises;
        bus.rx = 1'b0;
        repeat (4) @(posedge clk);
        #1 bus.rx = 1'b1;
        @(negedge clk);
        check("t4_busy_seen", int'(bus.busy), 1);
        idle(30);
        check("t4_idle", int'(bus.busy), 0);
        check("t4_no_valid", rises - r0, 0);
        check("t4_no_fe", fe_cnt - fe0, 0);
        // reset during bit 3 of 0xF0
        r0 = rises;
        drive_bit(1'b0);
        for (int i = 0; i < 3; i++) drive_bit(1'b0);
        bus.rx = 1'b0;
        repeat (8) @(posedge clk);
        #1;
        rst = 1'b1;
        bus.rx = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("t5_rst_data", int'(bus.rx_data), 0);
        check("t5_rst_valid", int'(bus.rx_valid), 0);
        check("t5_rst_busy", int'(bus.busy), 0);
        check("t5_rst_pulses", int'({bus.frame_err, bus.overrun}), 0);
        @(posedge clk);
        #1 rst = 1'b0;
        idle(10);
        send_byte(8'h0F, 1, 1'b1);
        idle(4);
        check("t5_next_byte", sb.size(), 0);
        check("t5_one_byte", rises - r0, 1);
        // accept 0x77 in the same cycle 0x99 completes
        bus.rx_ready = 1'b0;
        send_byte(8'h77, 1, 1'b1);
        idle(8);
        ov0 = ov_cnt;
        fork
            send_byte(8'h99, 1, 1'b1);
            begin
                n = 0;
                while (!bus.busy && n < 400) begin @(posedge clk); #1; n++; end
                while (bus.busy && n < 400) begin @(posedge clk); #1; n++; end
                check("t6_busy_timeout", int'(n < 400), 1);
                bus.rx_ready = 1'b1;
                @(posedge clk);
                #1 bus.rx_ready = 1'b0;
            end
        join
        @(negedge clk);
        check("t6_valid_kept", int'(bus.rx_valid), 1);
        check("t6_data_new", int'(bus.rx_data), 'h99);
        check("t6_no_overrun", ov_cnt - ov0, 0);
        @(posedge clk);
        #1 bus.rx_ready = 1'b1;
        idle(3);
        check("t6_sb_empty", sb.size(), 0);
        check("fe_ov_exclusive", both_cnt, 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
